// File: rtl/dram_pkg.sv
// Shared types and sizing for the DRAM cache-block responder and its MIG-style app port.
package dram_pkg;

   localparam int BURST_BITS        = 128;
   localparam int CACHE_BLOCK_BYTES = 64;
   localparam int DRAM_ADDR_BITS    = 27;
   localparam int BURST_STRIDE      = 8;
   localparam int BEATS             = CACHE_BLOCK_BYTES * 8 / BURST_BITS;
   localparam int BLOCK_BITS        = BEATS * BURST_BITS;
   localparam int MASK_BITS         = BURST_BITS / 8;
   // Beat index plus one extra bit that flags "all beats transferred".
   localparam int CNT_BITS          = $clog2(BEATS) + 1;

   localparam logic [2:0] APP_CMD_READ  = 3'b001;
   localparam logic [2:0] APP_CMD_WRITE = 3'b000;

   localparam logic [DRAM_ADDR_BITS-1:0] BLOCK_ALIGN_MASK = DRAM_ADDR_BITS'(32'h1F);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_DONE,
      ST_WR_ISSUE,
      ST_WR_DONE
   } state_e;

   function automatic logic [DRAM_ADDR_BITS-1:0] block_align(input logic [DRAM_ADDR_BITS-1:0] a);
      return a & ~BLOCK_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/dram_block_responder.sv
// Serves one 512-bit block read/write as four 128-bit app bursts; commands start the cycle after acceptance.
// Stalls on app_rdy / app_wdf_rdy with stable outputs; ready is low whenever a block is in flight.
module dram_block_responder
   import dram_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init_calib_complete,
   output logic                      read_ready,
   input  logic                      read_request,
   input  logic [DRAM_ADDR_BITS-1:0] read_address,
   output logic                      read_response,
   output logic [BLOCK_BITS-1:0]     read_data,
   output logic                      write_ready,
   input  logic                      write_request,
   input  logic [DRAM_ADDR_BITS-1:0] write_address,
   input  logic [BLOCK_BITS-1:0]     write_data,
   output logic [DRAM_ADDR_BITS-1:0] app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [BURST_BITS-1:0]     app_wdf_data,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   output logic [MASK_BITS-1:0]      app_wdf_mask,
   input  logic                      app_wdf_rdy,
   input  logic [BURST_BITS-1:0]     app_rd_data,
   input  logic                      app_rd_data_valid
);

   state_e                           state_q, state_d;
   logic [DRAM_ADDR_BITS-1:0]        base_q, base_d;
   logic [DRAM_ADDR_BITS-1:0]        pend_addr_q, pend_addr_d;
   logic                             pend_vld_q, pend_vld_d;
   logic [CNT_BITS-1:0]              cmd_cnt_q, cmd_cnt_d;
   logic [CNT_BITS-1:0]              data_cnt_q, data_cnt_d;
   logic [BEATS-1:0][BURST_BITS-1:0] wr_data_q, wr_data_d;
   logic [BEATS-1:0][BURST_BITS-1:0] read_data_q, read_data_d;
   logic [BEATS-2:0][BURST_BITS-1:0] rd_buf_q, rd_buf_d;
   logic                             idle_rdy;
   logic [DRAM_ADDR_BITS-1:0]        cmd_off;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         pend_addr_q <= '0;
         pend_vld_q  <= 1'b0;
         cmd_cnt_q   <= '0;
         data_cnt_q  <= '0;
         wr_data_q   <= '0;
         read_data_q <= '0;
         rd_buf_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         pend_addr_q <= pend_addr_d;
         pend_vld_q  <= pend_vld_d;
         cmd_cnt_q   <= cmd_cnt_d;
         data_cnt_q  <= data_cnt_d;
         wr_data_q   <= wr_data_d;
         read_data_q <= read_data_d;
         rd_buf_q    <= rd_buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      pend_addr_d = pend_addr_q;
      pend_vld_d  = pend_vld_q;
      cmd_cnt_d   = cmd_cnt_q;
      data_cnt_d  = data_cnt_q;
      wr_data_d   = wr_data_q;
      read_data_d = read_data_q;
      rd_buf_d    = rd_buf_q;

      // Gated by rst so every output, ready included, reads 0 while held in reset.
      idle_rdy      = rst && (state_q == ST_IDLE) && init_calib_complete;
      read_ready    = idle_rdy;
      write_ready   = idle_rdy;
      read_response = (state_q == ST_RD_DONE);
      read_data     = read_data_q;

      app_en  = ((state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE)) && !cmd_cnt_q[CNT_BITS-1];
      app_cmd = (app_en && (state_q == ST_RD_ISSUE)) ? APP_CMD_READ : APP_CMD_WRITE;
      cmd_off = DRAM_ADDR_BITS'(cmd_cnt_q[CNT_BITS-2:0]) * DRAM_ADDR_BITS'(BURST_STRIDE);
      app_addr = app_en ? (base_q + cmd_off) : '0;

      app_wdf_wren = (state_q == ST_WR_ISSUE) && !data_cnt_q[CNT_BITS-1];
      app_wdf_end  = app_wdf_wren;
      app_wdf_data = app_wdf_wren ? wr_data_q[data_cnt_q[CNT_BITS-2:0]] : '0;
      app_wdf_mask = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (idle_rdy && read_request) begin
               state_d    = ST_RD_ISSUE;
               base_d     = block_align(read_address);
               cmd_cnt_d  = '0;
               data_cnt_d = '0;
               // A write arriving with the read is parked and served right after it.
               if (write_request) begin
                  pend_vld_d  = 1'b1;
                  pend_addr_d = block_align(write_address);
                  wr_data_d   = write_data;
               end
            end else if (idle_rdy && write_request) begin
               state_d    = ST_WR_ISSUE;
               base_d     = block_align(write_address);
               wr_data_d  = write_data;
               cmd_cnt_d  = '0;
               data_cnt_d = '0;
            end
         end
         ST_RD_ISSUE: begin
            if (app_en && app_rdy) cmd_cnt_d = cmd_cnt_q + 1'b1;
            if (app_rd_data_valid && !data_cnt_q[CNT_BITS-1]) begin
               data_cnt_d = data_cnt_q + 1'b1;
               // Last beat goes straight into read_data so a partial block is never visible.
               if (data_cnt_q[CNT_BITS-2:0] == CNT_BITS'(BEATS - 1)) begin
                  read_data_d = {app_rd_data, rd_buf_q};
                  state_d     = ST_RD_DONE;
               end else begin
                  rd_buf_d[data_cnt_q[CNT_BITS-2:0]] = app_rd_data;
               end
            end
         end
         ST_RD_DONE: begin
            if (pend_vld_q) begin
               state_d    = ST_WR_ISSUE;
               base_d     = pend_addr_q;
               pend_vld_d = 1'b0;
               cmd_cnt_d  = '0;
               data_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_ISSUE: begin
            if (app_en && app_rdy)            cmd_cnt_d  = cmd_cnt_q + 1'b1;
            if (app_wdf_wren && app_wdf_rdy)  data_cnt_d = data_cnt_q + 1'b1;
            if (cmd_cnt_d[CNT_BITS-1] && data_cnt_d[CNT_BITS-1]) state_d = ST_WR_DONE;
         end
         ST_WR_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dram_block_responder.sv
// Directed bench for dram_block_responder: the bench plays the memory controller and checks every transfer.
module tb_dram_block_responder;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          init_calib_complete = 1'b0;
   logic          read_ready;
   logic          read_request = 1'b0;
   logic [26:0]   read_address = '0;
   logic          read_response;
   logic [511:0]  read_data;
   logic          write_ready;
   logic          write_request = 1'b0;
   logic [26:0]   write_address = '0;
   logic [511:0]  write_data = '0;
   logic [26:0]   app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy = 1'b0;
   logic [127:0]  app_wdf_data;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic [15:0]   app_wdf_mask;
   logic          app_wdf_rdy = 1'b0;
   logic [127:0]  app_rd_data = '0;
   logic          app_rd_data_valid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   dram_block_responder u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .init_calib_complete (init_calib_complete),
      .read_ready          (read_ready),
      .read_request        (read_request),
      .read_address        (read_address),
      .read_response       (read_response),
      .read_data           (read_data),
      .write_ready         (write_ready),
      .write_request       (write_request),
      .write_address       (write_address),
      .write_data          (write_data),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bench acts as controller: accepts every command, returns each read beat one cycle after its command.
   task automatic do_read(input string tag, input logic [26:0] addr, input logic [26:0] exp_base,
                          input logic [31:0] seed);
      int nc, nb;
      logic got_rsp;
      logic [511:0] exp_blk;
      logic [26:0] exp_addr;
      nc = 0; nb = 0; got_rsp = 1'b0;
      for (int k = 0; k < 4; k++) exp_blk[k*128 +: 128] = {4{seed + 32'(k)}};
      app_rdy = 1'b1;
      read_request = 1'b1; read_address = addr;
      tick();
      read_request = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         app_rd_data_valid = (nc > nb);
         app_rd_data = {4{seed + 32'(nb)}};
         if (app_en) begin
            exp_addr = exp_base + 27'(8 * nc);
            check({tag, "_addr"}, app_addr, exp_addr);
            check({tag, "_cmd"}, app_cmd, 3'b001);
            if (app_rdy) nc++;
         end
         if (app_rd_data_valid) nb++;
         if (read_response) begin
            got_rsp = 1'b1;
            check({tag, "_data"}, read_data, exp_blk);
            check({tag, "_rsp_cycle"}, c, 6);
            tick();
            check({tag, "_rsp_pulse"}, read_response, 1'b0);
            break;
         end
         tick();
      end
      app_rd_data_valid = 1'b0;
      check({tag, "_rsp_seen"}, got_rsp, 1'b1);
      check({tag, "_ncmd"}, nc, 4);
   endtask

   logic [26:0]  t1_addr [4] = '{27'h20, 27'h28, 27'h30, 27'h38};
   logic [127:0] t1_beat [4] = '{128'hA, 128'hB, 128'hC, 128'hD};
   logic [511:0] wd, wd2, exp3;
   int ncmd, nbeat, last_acc, rdy_cyc, rc, rb, wc, wb, rsp_cyc;

   initial begin
      // Reset state
      repeat (2) tick();
      check("rst_read_ready", read_ready, 1'b0);
      check("rst_write_ready", write_ready, 1'b0);
      check("rst_app_en", app_en, 1'b0);
      check("rst_wren", app_wdf_wren, 1'b0);
      check("rst_read_data", read_data, '0);
      check("rst_rsp", read_response, 1'b0);
      rst = 1'b1;
      init_calib_complete = 1'b1;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      tick();

      // Read at 0x25, beats returned at cycles 10..13
      check("t1_rd_ready", read_ready, 1'b1);
      read_request = 1'b1; read_address = 27'h25;
      tick();
      read_request = 1'b0;
      check("t1_ready_low", read_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("t1_app_en", app_en, 1'b1);
         check("t1_app_cmd", app_cmd, 3'b001);
         check("t1_app_addr", app_addr, t1_addr[k]);
         tick();
      end
      check("t1_en_stop", app_en, 1'b0);
      repeat (5) tick();
      for (int k = 0; k < 4; k++) begin
         app_rd_data_valid = 1'b1; app_rd_data = t1_beat[k];
         check("t1_no_early_rsp", read_response, 1'b0);
         tick();
      end
      app_rd_data_valid = 1'b0;
      check("t1_rsp", read_response, 1'b1);
      check("t1_data", read_data, {128'hD, 128'hC, 128'hB, 128'hA});
      tick();
      check("t1_rsp_pulse", read_response, 1'b0);
      check("t1_data_hold", read_data, {128'hD, 128'hC, 128'hB, 128'hA});
      check("t1_ready_back", read_ready, 1'b1);

      // Write at 0x40 with app_rdy low for 3 cycles
      wd = {128'h4444_0000_0000_0000_0000_0000_0000_0003, 128'h3333_0000_0000_0000_0000_0000_0000_0002,
            128'h2222_0000_0000_0000_0000_0000_0000_0001, 128'h1111_0000_0000_0000_0000_0000_0000_0000};
      write_request = 1'b1; write_address = 27'h40; write_data = wd;
      tick();
      write_request = 1'b0; write_data = ~wd;
      ncmd = 0; nbeat = 0; last_acc = 0; rdy_cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         app_rdy = (c >= 4);
         if (write_ready) begin rdy_cyc = c; break; end
         if (app_en) begin
            check("t2_addr", app_addr, 27'h40 + 27'(8 * ncmd));
            check("t2_cmd", app_cmd, 3'b000);
            if (app_rdy) begin ncmd++; last_acc = c; end
         end
         if (app_wdf_wren) begin
            check("t2_wdata", app_wdf_data, wd[nbeat*128 +: 128]);
            check("t2_wdf_end", app_wdf_end, 1'b1);
            check("t2_mask", app_wdf_mask, 16'h0);
            if (app_wdf_rdy) begin nbeat++; last_acc = c; end
         end
         tick();
      end
      check("t2_ncmd", ncmd, 4);
      check("t2_nbeat", nbeat, 4);
      check("t2_last_acc", last_acc, 7);
      check("t2_ready_cycle", rdy_cyc, 9);

      // Simultaneous read (0x100) and write (0x205 -> 0x200)
      wd2 = {4{128'h0BAD_F00D_0000_0000_1234_5678_9ABC_DEF0}};
      wd2[127:0] = 128'h5;
      for (int k = 0; k < 4; k++) exp3[k*128 +: 128] = {4{32'hC0DE0000 + 32'(k)}};
      app_rdy = 1'b1;
      read_request = 1'b1; write_request = 1'b1;
      read_address = 27'h100; write_address = 27'h205; write_data = wd2;
      tick();
      read_request = 1'b0; write_request = 1'b0; write_data = ~wd2;
      rc = 0; rb = 0; wc = 0; wb = 0; rsp_cyc = 0; rdy_cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         app_rd_data_valid = (rc > rb);
         app_rd_data = {4{32'hC0DE0000 + 32'(rb)}};
         if (read_ready || write_ready) begin rdy_cyc = c; break; end
         if (read_response) begin
            check("t3_rsp_once", rsp_cyc, 0);
            rsp_cyc = c;
            check("t3_rd_data", read_data, exp3);
         end
         if (app_en) begin
            if (app_cmd == 3'b001) begin
               check("t3_rd_addr", app_addr, 27'h100 + 27'(8 * rc));
               if (app_rdy) rc++;
            end else begin
               check("t3_wr_after_rsp", rsp_cyc != 0, 1'b1);
               check("t3_wr_addr", app_addr, 27'h200 + 27'(8 * wc));
               if (app_rdy) wc++;
            end
         end
         if (app_wdf_wren) begin
            check("t3_wren_after_rsp", rsp_cyc != 0, 1'b1);
            check("t3_wdata", app_wdf_data, wd2[wb*128 +: 128]);
            if (app_wdf_rdy) wb++;
         end
         if (app_rd_data_valid) rb++;
         tick();
      end
      app_rd_data_valid = 1'b0;
      check("t3_rc", rc, 4);
      check("t3_wc", wc, 4);
      check("t3_wb", wb, 4);
      check("t3_rsp_cycle", rsp_cyc, 6);
      check("t3_ready_cycle", rdy_cyc, 12);

      // Not calibrated: requests are dropped
      init_calib_complete = 1'b0;
      #1;
      check("t4_read_ready", read_ready, 1'b0);
      check("t4_write_ready", write_ready, 1'b0);
      read_request = 1'b1; write_request = 1'b1; read_address = 27'h80; write_address = 27'h80;
      tick();
      read_request = 1'b0; write_request = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t4_no_en", app_en, 1'b0);
         check("t4_no_wren", app_wdf_wren, 1'b0);
         tick();
      end
      init_calib_complete = 1'b1;
      #1;
      check("t4_ready_back", read_ready, 1'b1);
      check("t4_request_lost", app_en, 1'b0);

      // Reset after two read beats
      tick();
      read_request = 1'b1; read_address = 27'h80;
      tick();
      read_request = 1'b0;
      tick();
      app_rd_data_valid = 1'b1; app_rd_data = 128'h77;
      tick();
      app_rd_data = 128'h88;
      tick();
      app_rd_data_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("t5_en", app_en, 1'b0);
      check("t5_addr", app_addr, 27'h0);
      check("t5_read_data", read_data, '0);
      check("t5_read_ready", read_ready, 1'b0);
      check("t5_rsp", read_response, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      app_rd_data_valid = 1'b1; app_rd_data = 128'hDEAD;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("t5_stray_rsp", read_response, 1'b0);
         check("t5_stray_ready", read_ready, 1'b1);
      end
      app_rd_data_valid = 1'b0;
      do_read("t5_rd", 27'h3C0, 27'h3C0, 32'h5A5A0000);

      // Top-of-address-space block
      tick();
      do_read("t6_top", 27'h7FFFFE0, 27'h7FFFFE0, 32'h7E570000);
      tick();
      do_read("t6_align", 27'h7FFFFFF, 27'h7FFFFE0, 32'h3C3C0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
